// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: one-hot op bit positions,
// controller states and a one-hot test used by the top-level decoder.
package alu_pkg;

   localparam int NUM_OPS = 12;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_MUL = 2;
   localparam int OP_DIV = 3;
   localparam int OP_SHR = 4;
   localparam int OP_SHL = 5;
   localparam int OP_ROR = 6;
   localparam int OP_ROL = 7;
   localparam int OP_AND = 8;
   localparam int OP_OR  = 9;
   localparam int OP_NEG = 10;
   localparam int OP_NOT = 11;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_t;

   function automatic logic is_onehot(input logic [NUM_OPS-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring on
// magnitudes) sharing one adder, a double-width shift register and a counter.
module seq_muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             step,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int SHW = $clog2(WIDTH);
   localparam int AW  = WIDTH + 2;

   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             q1_q, q1_d;
   logic             mode_q, mode_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;

   logic [AW-1:0]    x, m_ext, sum, t;
   logic [WIDTH-1:0] rem;
   logic             sub, b_sub, b_add;

   always_comb begin
      b_sub = q_q[0] & ~q1_q;
      b_add = ~q_q[0] & q1_q;
      if (mode_q) begin
         x     = {acc_q[WIDTH:0], q_q[WIDTH-1]};
         m_ext = {2'b00, m_q};
         sub   = ~acc_q[AW-1];
      end else begin
         x     = acc_q;
         m_ext = {{2{m_q[WIDTH-1]}}, m_q};
         sub   = b_sub;
      end
      sum = x + (sub ? ~m_ext : m_ext) + AW'(sub);
   end

   always_comb begin
      acc_d  = acc_q;
      q_d    = q_q;
      q1_d   = q1_q;
      m_d    = m_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      negq_d = negq_q;
      negr_d = negr_q;
      t      = acc_q;
      if (load) begin
         acc_d  = '0;
         q1_d   = 1'b0;
         cnt_d  = SHW'(WIDTH - 1);
         mode_d = mode;
         negq_d = mode & (a[WIDTH-1] ^ b[WIDTH-1]);
         negr_d = mode & a[WIDTH-1];
         q_d    = mode ? (a[WIDTH-1] ? -a : a) : b;
         m_d    = mode ? (b[WIDTH-1] ? -b : b) : a;
      end else if (step) begin
         cnt_d = cnt_q - 1'b1;
         if (mode_q) begin
            acc_d = sum;
            q_d   = {q_q[WIDTH-2:0], ~sum[AW-1]};
         end else begin
            t     = (b_sub | b_add) ? sum : acc_q;
            acc_d = {t[AW-1], t[AW-1:1]};
            q_d   = {t[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
         end
      end
   end

   // Results reflect the state after the current step, so the final step's
   // outcome is available at the same edge that ends the run.
   always_comb begin
      rem = acc_d[AW-1] ? acc_d[WIDTH-1:0] + m_q : acc_d[WIDTH-1:0];
      if (mode_q) begin
         res_lo = negq_q ? -q_d : q_d;
         res_hi = negr_q ? -rem : rem;
      end else begin
         res_lo = q_d;
         res_hi = acc_d[WIDTH-1:0];
      end
   end

   assign last = (cnt_q == '0);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         acc_q  <= '0;
         q_q    <= '0;
         q1_q   <= 1'b0;
         m_q    <= '0;
         cnt_q  <= '0;
         mode_q <= 1'b0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         q_q    <= q_d;
         q1_q   <= q1_d;
         m_q    <= m_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered one-hot controlled ALU with Zhigh/Zlow result pair and
// multi-cycle signed MUL/DIV behind a start/busy/done handshake.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [NUM_OPS-1:0] op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   zlow,
   output logic [WIDTH-1:0]   zhigh,
   output logic               err_op,
   output logic               err_dz
);

   localparam int SHW = $clog2(WIDTH);

   state_t state_q, state_d;
   logic [WIDTH-1:0] zlow_q, zlow_d;
   logic [WIDTH-1:0] zhigh_q, zhigh_d;
   logic             err_op_q, err_op_d;
   logic             err_dz_q, err_dz_d;

   logic               op_ok, load, step, last;
   logic [NUM_OPS-1:0] op_s;
   logic [SHW-1:0]     sh;
   logic [WIDTH-1:0]   sc_res, core_lo, core_hi;

   assign op_ok = is_onehot(op);
   assign op_s  = op_ok ? op : NUM_OPS'(1);
   assign sh    = b[SHW-1:0];

   always_comb begin
      sc_res = '0;
      unique case (1'b1)
         op_s[OP_ADD]: sc_res = a + b;
         op_s[OP_SUB]: sc_res = a - b;
         op_s[OP_SHR]: sc_res = a >> sh;
         op_s[OP_SHL]: sc_res = a << sh;
         op_s[OP_ROR]: sc_res = WIDTH'({a, a} >> sh);
         op_s[OP_ROL]: sc_res = WIDTH'(({a, a} << sh) >> WIDTH);
         op_s[OP_AND]: sc_res = a & b;
         op_s[OP_OR]:  sc_res = a | b;
         op_s[OP_NEG]: sc_res = -b;
         op_s[OP_NOT]: sc_res = ~b;
         default:      sc_res = '0;
      endcase
   end

   seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .clr    (clr),
      .load   (load),
      .step   (step),
      .mode   (op[OP_DIV]),
      .a      (a),
      .b      (b),
      .last   (last),
      .res_lo (core_lo),
      .res_hi (core_hi)
   );

   always_comb begin
      state_d  = state_q;
      zlow_d   = zlow_q;
      zhigh_d  = zhigh_q;
      err_op_d = err_op_q;
      err_dz_d = err_dz_q;
      load     = 1'b0;
      step     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FINISH;
               if (!op_ok) begin
                  err_op_d = 1'b1;
                  err_dz_d = 1'b0;
               end else if (op[OP_MUL] || (op[OP_DIV] && b != '0)) begin
                  load    = 1'b1;
                  state_d = RUN;
               end else if (op[OP_DIV]) begin
                  zlow_d   = '1;
                  zhigh_d  = a;
                  err_op_d = 1'b0;
                  err_dz_d = 1'b1;
               end else begin
                  zlow_d   = sc_res;
                  zhigh_d  = '0;
                  err_op_d = 1'b0;
                  err_dz_d = 1'b0;
               end
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_d  = FINISH;
               zlow_d   = core_lo;
               zhigh_d  = core_hi;
               err_op_d = 1'b0;
               err_dz_d = 1'b0;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= IDLE;
         zlow_q   <= '0;
         zhigh_q  <= '0;
         err_op_q <= 1'b0;
         err_dz_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         zlow_q   <= zlow_d;
         zhigh_q  <= zhigh_d;
         err_op_q <= err_op_d;
         err_dz_q <= err_dz_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == FINISH);
   assign zlow   = zlow_q;
   assign zhigh  = zhigh_q;
   assign err_op = err_op_q;
   assign err_dz = err_dz_q;

endmodule
